lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Parametrised load/store unit. It takes one decoded memory op at a time from the core control path and runs a variable-latency req/ack handshake to data memory.
- Handles byte-lane extract with sign/zero extension, sub-word store merge, and misalignment detection.
- Replaces the inline load/store handling in the control unit.
- Supports 32- or 64-bit data and two store modes: byte-enable, or read-modify-write for memories without strobes.

Parameters:
- DATA_W, 32, data path width; legal values 32 or 64.
- ADDR_W, 32, memory address width, ≤ DATA_W.
- RMW_STORE, 0: 0 = sub-word stores use mem_be; 1 = sub-word stores do read-then-write with mem_be all ones.

Ports:
- clk in 1: clock.
- rst in 1: synchronous, active-high reset.
- op_valid in 1: op presented.
- op_ready out 1: unit can accept an op.
- op_load in 1: 1 = load, 0 = store.
- op_size in 2: 00 byte, 01 half, 10 word, 11 dword.
- op_unsigned in 1: zero-extend loads (lbu/lhu/lwu).
- base in DATA_W: rs1 value.
- offset in DATA_W: sign-extended immediate.
- store_data in DATA_W: rs2 value.
- resp_valid out 1: one-cycle completion pulse.
- resp_misalign out 1: qualifies resp_valid; access faulted.
- rd_data out DATA_W: load result, valid with resp_valid.
- mem_req out 1: memory request.
- mem_we out 1: write request.
- mem_addr out ADDR_W: word-aligned address.
- mem_wdata out DATA_W: write data.
- mem_be out DATA_W/8: byte enables.
- mem_ack in 1: request completed; mem_rdata valid this cycle.
- mem_rdata in DATA_W: read data.

Behaviour:
- Reset (rst high at a clk edge):
  - State goes to IDLE.
  - op_ready=1.
  - resp_valid, resp_misalign, mem_req and mem_we = 0.
  - rd_data, mem_addr, mem_wdata and mem_be = 0.
- Reset mid-operation abandons the op: mem_req drops on the next edge and no resp_valid is issued. The memory side must tolerate a withdrawn request.
- Accept:
  - op_valid && op_ready at an edge latches all op fields.
  - ea = base + offset, wrapped mod 2^DATA_W.
  - lane = ea[log2(DATA_W/8)-1:0].
  - op_ready=0 until the cycle after resp_valid.
- Misalignment: lane not a multiple of the access size, or op_size=11 with DATA_W=32.
  - No memory access.
  - Next cycle: resp_valid=1, resp_misalign=1, rd_data=0.
- States:
  - IDLE: on accept, go to FAULT if misaligned. Otherwise go to RD for loads and for RMW sub-word stores; go to WR for all other stores.
  - RD: mem_req=1, mem_we=0, mem_be=all ones. Hold until mem_ack. On ack, capture mem_rdata. A load goes to RESP; an RMW store goes to WR with merged data.
  - WR: mem_req=1, mem_we=1.
    - RMW_STORE=0: mem_be has size-many bits set from lane; store_data low bytes are replicated into the selected lanes.
    - RMW_STORE=1: mem_be=all ones; mem_wdata = captured word with the selected lanes replaced.
    - Hold until mem_ack, then go to RESP.
  - RESP: resp_valid=1 for one cycle, then IDLE with op_ready=1.
  - FAULT: resp_valid=1, resp_misalign=1, then IDLE.
- mem_addr = ea[ADDR_W-1:0] with the lane bits cleared. It is stable, with all mem_* outputs, for as long as mem_req=1.
- mem_ack arriving while mem_req=0 is ignored.
- mem_ack in the first cycle of mem_req is legal. Minimum latency is accept → mem_req at edge+1 → ack that cycle → resp_valid at edge+2.
- Load extract: bytes size×8 starting at lane×8, then sign-extended (op_unsigned=0) or zero-extended (op_unsigned=1) to DATA_W. A word load with DATA_W=32 ignores op_unsigned.
- Stores leave rd_data unchanged (holds its previous value).
- Back-to-back ops: the earliest next accept is the edge after resp_valid. There is no overlap.

Decomposition:
- Shared package lsu_pkg:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - state enum IDLE/RD/WR/RESP/FAULT;
  - function size_bytes(op_size).
- Sub-module lsu_align (combinational, parametrised on DATA_W) provides:
  - load lane extract and extension;
  - store lane replicate and merge;
  - byte-enable generation;
  - misalignment check.
- lsu_ctrl holds the FSM and registers.

Test Plan:
- DATA_W=32, RMW_STORE=0. Load byte signed, base=0x100, offset=3, mem_rdata=0x80FF_1234 with ack after 2 cycles → mem_addr=0x100, rd_data=0xFFFF_FF80, resp_valid exactly once.
- Same setup with op_unsigned=1, half load, offset=2 → rd_data=0x0000_80FF.
- Store half: base=0x200, offset=2, store_data=0xAAAA_BEEF, RMW_STORE=0 → mem_we=1, mem_be=4'b1100, mem_wdata[31:16]=0xBEEF, no read cycle.
- RMW_STORE=1, store byte: base=0x300, offset=1, store_data=0x5A, read returns 0x1122_3344 → read, then write with mem_wdata=0x1122_5A44 and mem_be=4'hF.
- Word load: base=0x100, offset=-2 (ea=0xFE) → no mem_req, next-cycle resp_valid=1, resp_misalign=1, rd_data=0. Also op_size=11 at DATA_W=32 → same fault response.
- rst asserted while in RD with mem_ack held low → mem_req=0 after the edge, no resp_valid, op_ready=1. A following load completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [2:0] {IDLE, RD, WR, RESP, FAULT} lsu_state_e;

    function automatic int unsigned size_bytes(input logic [1:0] op_size);
        return 32'd1 << op_size;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend, store replicate/merge, byte enables,
// misalignment detection.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned NB = DATA_W / 8,
    localparam int unsigned LW = $clog2(NB)
) (
    input  logic [1:0]        size_i,
    input  logic [LW-1:0]     lane_i,
    input  logic              unsigned_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [DATA_W-1:0] merge_base_i,
    output logic [DATA_W-1:0] load_data_o,
    output logic [DATA_W-1:0] repl_data_o,
    output logic [DATA_W-1:0] merged_data_o,
    output logic [NB-1:0]     be_o,
    output logic              misalign_o
);

    int unsigned nb_raw;
    int unsigned nb;
    int unsigned nbits;
    int unsigned lane_int;
    logic [DATA_W-1:0] shifted;
    logic ext_bit;

    always_comb begin
        nb_raw   = size_bytes(size_i);
        // Clamp so an illegal dword on a 32-bit path never indexes past the word.
        nb       = (nb_raw > NB) ? NB : nb_raw;
        nbits    = nb * 8;
        lane_int = 32'(lane_i);

        misalign_o = ((lane_int & (nb_raw - 1)) != 0) || ((size_i == SZ_D) && (DATA_W == 32));

        shifted = rdata_i >> (lane_int * 8);
        case (size_i)
            SZ_B:    ext_bit = ~unsigned_i & shifted[7];
            SZ_H:    ext_bit = ~unsigned_i & shifted[15];
            default: ext_bit = ~unsigned_i & shifted[31];
        endcase
        load_data_o = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            load_data_o[i] = (i < nbits) ? shifted[i] : ext_bit;
        end

        case (size_i)
            SZ_B:    repl_data_o = {NB{store_data_i[7:0]}};
            SZ_H:    repl_data_o = {(NB / 2){store_data_i[15:0]}};
            SZ_W:    repl_data_o = {(NB / 4){store_data_i[31:0]}};
            default: repl_data_o = store_data_i;
        endcase

        be_o = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            be_o[i] = (i >= lane_int) && (i < lane_int + nb);
        end

        merged_data_o = merge_base_i;
        for (int unsigned i = 0; i < NB; i++) begin
            if (be_o[i]) begin
                merged_data_o[i*8 +: 8] = repl_data_o[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: one op at a time, req/ack handshake to data memory, optional
// read-modify-write for sub-word stores on strobe-less memories.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RMW_STORE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic                  op_load,
    input  logic [1:0]            op_size,
    input  logic                  op_unsigned,
    input  logic [DATA_W-1:0]     base,
    input  logic [DATA_W-1:0]     offset,
    input  logic [DATA_W-1:0]     store_data,
    output logic                  resp_valid,
    output logic                  resp_misalign,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned LW = $clog2(NB);
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(NB - 1);

    lsu_state_e state_q, state_d;
    logic op_ready_q, op_ready_d;
    logic resp_valid_q, resp_valid_d;
    logic resp_misalign_q, resp_misalign_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic mem_req_q, mem_req_d;
    logic mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [NB-1:0] mem_be_q, mem_be_d;
    logic ld_q, ld_d;
    logic [1:0] size_q, size_d;
    logic uns_q, uns_d;
    logic [LW-1:0] lane_q, lane_d;
    logic [DATA_W-1:0] sdata_q, sdata_d;

    logic [DATA_W-1:0] ea;
    logic in_idle;
    logic [1:0] al_size;
    logic [LW-1:0] al_lane;
    logic al_uns;
    logic [DATA_W-1:0] al_sdata;
    logic [DATA_W-1:0] al_load, al_repl, al_merged;
    logic [NB-1:0] al_be;
    logic al_misalign;

    assign ea       = base + offset;
    assign in_idle  = (state_q == IDLE);
    // In IDLE the aligner looks at the incoming op; afterwards at the latched one.
    assign al_size  = in_idle ? op_size : size_q;
    assign al_lane  = in_idle ? ea[LW-1:0] : lane_q;
    assign al_uns   = in_idle ? op_unsigned : uns_q;
    assign al_sdata = in_idle ? store_data : sdata_q;

    lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .size_i        (al_size),
        .lane_i        (al_lane),
        .unsigned_i    (al_uns),
        .rdata_i       (mem_rdata),
        .store_data_i  (al_sdata),
        .merge_base_i  (mem_rdata),
        .load_data_o   (al_load),
        .repl_data_o   (al_repl),
        .merged_data_o (al_merged),
        .be_o          (al_be),
        .misalign_o    (al_misalign)
    );

    always_comb begin
        state_d         = state_q;
        op_ready_d      = op_ready_q;
        resp_valid_d    = 1'b0;
        resp_misalign_d = 1'b0;
        rd_data_d       = rd_data_q;
        mem_req_d       = mem_req_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_be_d        = mem_be_q;
        ld_d            = ld_q;
        size_d          = size_q;
        uns_d           = uns_q;
        lane_d          = lane_q;
        sdata_d         = sdata_q;

        case (state_q)
            IDLE: begin
                if (op_valid && op_ready_q) begin
                    op_ready_d = 1'b0;
                    ld_d       = op_load;
                    size_d     = op_size;
                    uns_d      = op_unsigned;
                    lane_d     = ea[LW-1:0];
                    sdata_d    = store_data;
                    if (al_misalign) begin
                        state_d         = FAULT;
                        resp_valid_d    = 1'b1;
                        resp_misalign_d = 1'b1;
                        rd_data_d       = '0;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = ea[ADDR_W-1:0] & ~LANE_MASK;
                        if (op_load || (RMW_STORE != 0 && size_bytes(op_size) < NB)) begin
                            state_d  = RD;
                            mem_we_d = 1'b0;
                            mem_be_d = '1;
                        end else begin
                            state_d     = WR;
                            mem_we_d    = 1'b1;
                            mem_be_d    = al_be;
                            mem_wdata_d = al_repl;
                        end
                    end
                end
            end
            RD: begin
                if (mem_ack) begin
                    if (ld_q) begin
                        state_d      = RESP;
                        mem_req_d    = 1'b0;
                        resp_valid_d = 1'b1;
                        rd_data_d    = al_load;
                    end else begin
                        state_d     = WR;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = al_merged;
                    end
                end
            end
            WR: begin
                if (mem_ack) begin
                    state_d      = RESP;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                end
            end
            RESP, FAULT: begin
                state_d    = IDLE;
                op_ready_d = 1'b1;
            end
            default: begin
                state_d    = IDLE;
                op_ready_d = 1'b1;
                mem_req_d  = 1'b0;
                mem_we_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            op_ready_q      <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_misalign_q <= 1'b0;
            rd_data_q       <= '0;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_be_q        <= '0;
            ld_q            <= 1'b0;
            size_q          <= SZ_B;
            uns_q           <= 1'b0;
            lane_q          <= '0;
            sdata_q         <= '0;
        end else begin
            state_q         <= state_d;
            op_ready_q      <= op_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_misalign_q <= resp_misalign_d;
            rd_data_q       <= rd_data_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_be_q        <= mem_be_d;
            ld_q            <= ld_d;
            size_q          <= size_d;
            uns_q           <= uns_d;
            lane_q          <= lane_d;
            sdata_q         <= sdata_d;
        end
    end

    assign op_ready      = op_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_misalign = resp_misalign_q;
    assign rd_data       = rd_data_q;
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_be        = mem_be_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a byte-enable instance and a read-modify-write instance.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        op_load = 1'b0;
    logic [1:0]  op_size = SZ_B;
    logic        op_unsigned = 1'b0;
    logic [31:0] base = '0, offset = '0, store_data = '0, mem_rdata = '0;
    logic        op_valid0 = 1'b0, op_valid1 = 1'b0, mem_ack0 = 1'b0, mem_ack1 = 1'b0;
    logic        sel = 1'b0;

    logic        op_ready0, resp_valid0, resp_mis0, mem_req0, mem_we0;
    logic [31:0] rd_data0, mem_addr0, mem_wdata0;
    logic [3:0]  mem_be0;
    logic        op_ready1, resp_valid1, resp_mis1, mem_req1, mem_we1;
    logic [31:0] rd_data1, mem_addr1, mem_wdata1;
    logic [3:0]  mem_be1;

    lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .RMW_STORE(0)) u_dut (
        .clk(clk), .rst(rst), .op_valid(op_valid0), .op_ready(op_ready0), .op_load(op_load),
        .op_size(op_size), .op_unsigned(op_unsigned), .base(base), .offset(offset),
        .store_data(store_data), .resp_valid(resp_valid0), .resp_misalign(resp_mis0),
        .rd_data(rd_data0), .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .mem_be(mem_be0), .mem_ack(mem_ack0), .mem_rdata(mem_rdata)
    );

    lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .RMW_STORE(1)) u_dut_rmw (
        .clk(clk), .rst(rst), .op_valid(op_valid1), .op_ready(op_ready1), .op_load(op_load),
        .op_size(op_size), .op_unsigned(op_unsigned), .base(base), .offset(offset),
        .store_data(store_data), .resp_valid(resp_valid1), .resp_misalign(resp_mis1),
        .rd_data(rd_data1), .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_be(mem_be1), .mem_ack(mem_ack1), .mem_rdata(mem_rdata)
    );

    logic        o_op_ready, o_resp_valid, o_resp_mis, o_mem_req, o_mem_we;
    logic [31:0] o_rd_data, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;
    assign o_op_ready   = sel ? op_ready1 : op_ready0;
    assign o_resp_valid = sel ? resp_valid1 : resp_valid0;
    assign o_resp_mis   = sel ? resp_mis1 : resp_mis0;
    assign o_mem_req    = sel ? mem_req1 : mem_req0;
    assign o_mem_we     = sel ? mem_we1 : mem_we0;
    assign o_rd_data    = sel ? rd_data1 : rd_data0;
    assign o_mem_addr   = sel ? mem_addr1 : mem_addr0;
    assign o_mem_wdata  = sel ? mem_wdata1 : mem_wdata0;
    assign o_mem_be     = sel ? mem_be1 : mem_be0;

    typedef struct {
        logic        sel;
        logic        ld;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] base;
        logic [31:0] offset;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int unsigned dly;
        logic        mis;
        logic [31:0] rd;
        logic [31:0] addr;
        int unsigned nrd;
        int unsigned nwr;
        logic [3:0]  be;
        logic [31:0] wmask;
        logic [31:0] wdata;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];
    int checks = 0;
    int errors = 0;
    logic [31:0] prev_rd[2];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int unsigned wait_n = 0, nrd = 0, nwr = 0, nresp = 0, cyc = 0, resp_cyc = 0;
        logic got_mis = 1'b0, done = 1'b0, ack;
        logic [31:0] got_rd = '0, got_addr = '0, got_wdata = '0, exp_rd;
        logic [3:0] got_be = '0;
        @(negedge clk);
        sel = v.sel;
        #1;
        chk($sformatf("v%0d_ready_before", idx), {31'd0, o_op_ready}, 32'd1);
        op_load = v.ld; op_size = v.sz; op_unsigned = v.uns;
        base = v.base; offset = v.offset; store_data = v.sdata;
        op_valid0 = !v.sel; op_valid1 = v.sel;
        @(negedge clk);
        op_valid0 = 1'b0; op_valid1 = 1'b0;
        while (!done && cyc < 40) begin
            ack = 1'b0;
            if (nresp > 0 && !o_resp_valid) done = 1'b1;
            if (o_resp_valid) begin
                nresp++;
                resp_cyc = cyc;
                got_mis = o_resp_mis;
                got_rd = o_rd_data;
            end
            if (o_mem_req) begin
                got_addr = o_mem_addr;
                if (wait_n == v.dly) begin
                    ack = 1'b1;
                    wait_n = 0;
                    if (o_mem_we) begin
                        nwr++;
                        got_be = o_mem_be;
                        got_wdata = o_mem_wdata;
                    end else begin
                        nrd++;
                        mem_rdata = v.rdata;
                    end
                end else begin
                    wait_n++;
                end
            end
            if (v.sel) mem_ack1 = ack; else mem_ack0 = ack;
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        mem_ack0 = 1'b0; mem_ack1 = 1'b0;
        exp_rd = (v.ld || v.mis) ? v.rd : prev_rd[v.sel];
        prev_rd[v.sel] = exp_rd;
        chk($sformatf("v%0d_resp_count", idx), nresp, 1);
        chk($sformatf("v%0d_resp_cycle", idx), resp_cyc, (v.nrd + v.nwr) * (v.dly + 1));
        chk($sformatf("v%0d_misalign", idx), {31'd0, got_mis}, {31'd0, v.mis});
        chk($sformatf("v%0d_rd_data", idx), got_rd, exp_rd);
        chk($sformatf("v%0d_reads", idx), nrd, v.nrd);
        chk($sformatf("v%0d_writes", idx), nwr, v.nwr);
        chk($sformatf("v%0d_ready_after", idx), {31'd0, o_op_ready}, 32'd1);
        if (v.nrd + v.nwr > 0) chk($sformatf("v%0d_addr", idx), got_addr, v.addr);
        if (v.nwr > 0) begin
            chk($sformatf("v%0d_be", idx), {28'd0, got_be}, {28'd0, v.be});
            chk($sformatf("v%0d_wdata", idx), got_wdata & v.wmask, v.wdata);
        end
    endtask

    initial begin
        //        sel ld sz   uns base          offset        sdata         rdata         dly
        //        mis rd            addr          nrd nwr be      wmask         wdata
        vecs[0]  = '{0, 1, SZ_B, 0, 'h100, 'h3, 0, 'h80FF1234, 2,
                     0, 'hFFFFFF80, 'h100, 1, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, SZ_H, 1, 'h100, 'h2, 0, 'h80FF1234, 2,
                     0, 'h000080FF, 'h100, 1, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, SZ_H, 0, 'h200, 'h2, 'hAAAABEEF, 0, 1,
                     0, 0, 'h200, 0, 1, 4'b1100, 'hFFFF0000, 'hBEEF0000};
        vecs[3]  = '{1, 0, SZ_B, 0, 'h300, 'h1, 'h5A, 'h11223344, 1,
                     0, 0, 'h300, 1, 1, 4'hF, 'hFFFFFFFF, 'h11225A44};
        vecs[4]  = '{0, 1, SZ_W, 0, 'h100, 'hFFFFFFFE, 0, 0, 0,
                     1, 0, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{0, 1, SZ_D, 0, 'h100, 'h0, 0, 0, 0,
                     1, 0, 0, 0, 0, 0, 0, 0};
        vecs[6]  = '{0, 1, SZ_W, 0, 'h1000, 'h4, 0, 'h87654321, 0,
                     0, 'h87654321, 'h1004, 1, 0, 0, 0, 0};
        vecs[7]  = '{0, 1, SZ_H, 0, 'h0, 'h2, 0, 'h80010000, 1,
                     0, 'hFFFF8001, 'h0, 1, 0, 0, 0, 0};
        vecs[8]  = '{0, 0, SZ_B, 0, 'h400, 'h1, 'h12345678, 0, 0,
                     0, 0, 'h400, 0, 1, 4'b0010, 'h0000FF00, 'h00007800};
        vecs[9]  = '{0, 1, SZ_H, 0, 'h400, 'h1, 0, 0, 0,
                     1, 0, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{0, 0, SZ_W, 0, 'h400, 'h2, 'hFFFFFFFF, 0, 0,
                     1, 0, 0, 0, 0, 0, 0, 0};
        vecs[11] = '{1, 0, SZ_W, 0, 'h500, 'h0, 'hDEADBEEF, 'h0BADF00D, 1,
                     0, 0, 'h500, 0, 1, 4'hF, 'hFFFFFFFF, 'hDEADBEEF};
        vecs[12] = '{1, 1, SZ_B, 1, 'h600, 'h0, 0, 'h000000F0, 0,
                     0, 'h000000F0, 'h600, 1, 0, 0, 0, 0};
        vecs[13] = '{0, 1, SZ_W, 0, 'hFFFFFFFC, 'h8, 0, 'h13579BDF, 3,
                     0, 'h13579BDF, 'h4, 1, 0, 0, 0, 0};
        prev_rd[0] = '0;
        prev_rd[1] = '0;

        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, op_ready0}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid0}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req0}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we0}, 32'd0);
        chk("rst_rd_data", rd_data0, 32'd0);
        chk("rst_mem_addr", mem_addr0, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be0}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // Ack with no request outstanding must be ignored.
        @(negedge clk);
        sel = 1'b0;
        mem_ack0 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("spurious_ack_resp", {31'd0, resp_valid0}, 32'd0);
            chk("spurious_ack_req", {31'd0, mem_req0}, 32'd0);
        end
        mem_ack0 = 1'b0;

        // Reset while a read is outstanding abandons the op.
        op_load = 1'b1; op_size = SZ_W; base = 'h100; offset = '0;
        op_valid0 = 1'b1;
        @(negedge clk);
        op_valid0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_req_before", {31'd0, mem_req0}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_req_after", {31'd0, mem_req0}, 32'd0);
        chk("midrst_ready", {31'd0, op_ready0}, 32'd1);
        repeat (3) begin
            chk("midrst_no_resp", {31'd0, resp_valid0}, 32'd0);
            @(negedge clk);
        end
        prev_rd[0] = '0;
        run_vec(100, vecs[6]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
